// File: rtl/digit_segment_driver.sv
// Binary-to-BCD (serial double-dabble) driver for a 2-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks a leading zero in the tens column.
module digit_segment_driver #(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int MAX_VALUE      = 99
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] Number_Data,
    input  logic       Number_Valid,
    output logic       Busy,
    input  logic [1:0] Column_Scan_Sig,
    output logic [7:0] Row_Scan_Sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] MAXV = 7'(MAX_VALUE);

    state_t     state, state_nxt;
    logic [6:0] bin_q;
    logic [7:0] bcd_q;
    logic [2:0] bit_cnt;
    logic       ovf_q;
    logic [3:0] tens_q, units_q;
    logic       disp_ovf_q;
    logic [7:0] bcd_adj;
    logic [7:0] row_nxt;
    logic [7:0] seg_base;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        c = 8'hFF;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Number_Valid) state_nxt = CONV;
            CONV: if (bit_cnt == 3'd6) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    // Add-3 correction on each BCD nibble before the shift
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end

    // Conversion datapath and display registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt    <= '0;
            ovf_q      <= 1'b0;
            tens_q     <= '0;
            units_q    <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Number_Valid) begin
                        bin_q   <= (Number_Data > MAXV) ? MAXV : Number_Data;
                        ovf_q   <= (Number_Data > MAXV);
                        bcd_q   <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj[6:0], bin_q, 1'b0};
                    bit_cnt        <= bit_cnt + 3'd1;
                end
                DONE: begin
                    tens_q     <= bcd_q[7:4];
                    units_q    <= bcd_q[3:0];
                    disp_ovf_q <= ovf_q;
                end
                default: ;
            endcase
        end
    end

    // Segment pattern for the selected column
    always_comb begin
        seg_base = 8'hFF;
        case (Column_Scan_Sig)
            2'b10: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (tens_q == 4'd0)
                    seg_base = 8'hFF;
                else
                    seg_base = seg_code(tens_q) & ~{disp_ovf_q, 7'b0};
`else
                seg_base = seg_code(tens_q) & ~{disp_ovf_q, 7'b0};
`endif
            end
            2'b01:   seg_base = seg_code(units_q) & ~{disp_ovf_q, 7'b0};
            default: seg_base = 8'hFF;
        endcase
        row_nxt = (SEG_ACTIVE_LOW != 0) ? seg_base : ~seg_base;
    end

    // Registered segment output
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) Row_Scan_Sig <= 8'hFF;
        else        Row_Scan_Sig <= row_nxt;
    end

endmodule

// File: tb/tb_digit_segment_driver.sv
// Directed self-checking bench for digit_segment_driver.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_digit_segment_driver;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [6:0] Number_Data;
    logic       Number_Valid;
    logic       Busy;
    logic [1:0] Column_Scan_Sig;
    logic [7:0] Row_Scan_Sig;

    int total = 0;
    int bad   = 0;

    digit_segment_driver dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .Number_Data    (Number_Data),
        .Number_Valid   (Number_Valid),
        .Busy           (Busy),
        .Column_Scan_Sig(Column_Scan_Sig),
        .Row_Scan_Sig   (Row_Scan_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_row(input string name, input logic [7:0] exp);
        total++;
        if (Row_Scan_Sig !== exp) begin
            bad++;
            $display("FAIL %s: row got %h want %h", name, Row_Scan_Sig, exp);
        end
    endtask

    task automatic chk_busy(input string name, input logic exp);
        total++;
        if (Busy !== exp) begin
            bad++;
            $display("FAIL %s: busy got %b want %b", name, Busy, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy got %b want 0 (timeout)", name, Busy);
        end
    endtask

    task automatic load(input logic [6:0] v);
        Number_Data  = v;
        Number_Valid = 1'b1;
        tick();
        Number_Valid = 1'b0;
    endtask

    task automatic show(input logic [1:0] col, input string name,
                        input logic [7:0] exp);
        Column_Scan_Sig = col;
        tick();
        chk_row(name, exp);
    endtask

    task automatic test_reset();
        RST_N           = 1'b0;
        Number_Data     = '0;
        Number_Valid    = 1'b0;
        Column_Scan_Sig = 2'b10;
        tick();
        tick();
        chk_row("reset_row", 8'hFF);
        chk_busy("reset_busy", 1'b0);
        RST_N = 1'b1;
        tick();
        chk_row("reset_release_c0", 8'hC0);
        chk_busy("reset_release_busy", 1'b0);
    endtask

    task automatic test_convert_42();
        Column_Scan_Sig = 2'b00;
        load(7'd42);
        for (int i = 0; i < 8; i++) begin
            chk_busy($sformatf("busy42_c%0d", i), 1'b1);
            tick();
        end
        chk_busy("busy42_fall", 1'b0);
        show(2'b10, "42_tens", 8'h99);
        show(2'b01, "42_units", 8'hA4);
        show(2'b00, "42_blank00", 8'hFF);
        show(2'b11, "42_blank11", 8'hFF);
    endtask

    task automatic test_overflow();
        load(7'd120);
        wait_idle("ovf_idle");
        show(2'b10, "ovf_tens", 8'h10);
        show(2'b01, "ovf_units", 8'h10);
        show(2'b00, "ovf_blank", 8'hFF);
    endtask

    task automatic test_boundary_99();
        load(7'd99);
        wait_idle("b99_idle");
        show(2'b10, "b99_tens", 8'h90);
        show(2'b01, "b99_units", 8'h90);
    endtask

    task automatic test_ignore_busy();
        load(7'd57);
        tick();
        Number_Data  = 7'd63;
        Number_Valid = 1'b1;
        tick();
        tick();
        Number_Valid = 1'b0;
        wait_idle("ign_idle");
        tick();
        chk_busy("ign_no_reload", 1'b0);
        show(2'b10, "ign_tens", 8'h92);
        show(2'b01, "ign_units", 8'hF8);
    endtask

    task automatic test_valid_held();
        Number_Data  = 7'd13;
        Number_Valid = 1'b1;
        tick();
        wait_idle("held_fall");
        tick();
        chk_busy("held_reload", 1'b1);
        Number_Valid = 1'b0;
        wait_idle("held_idle");
        show(2'b10, "held_tens", 8'hF9);
        show(2'b01, "held_units", 8'hB0);
    endtask

    task automatic test_reset_mid_conv();
        load(7'd88);
        tick();
        tick();
        tick();
        chk_busy("mid_busy", 1'b1);
        RST_N = 1'b0;
        #1;
        chk_busy("mid_rst_busy", 1'b0);
        chk_row("mid_rst_row", 8'hFF);
        tick();
        RST_N = 1'b1;
        show(2'b10, "mid_tens", 8'hC0);
        show(2'b01, "mid_units", 8'hC0);
    endtask

    task automatic test_leading_zero();
        load(7'd7);
        wait_idle("lz_idle");
`ifdef LEADING_ZERO_BLANK_EN
        show(2'b10, "lz_tens", 8'hFF);
`else
        show(2'b10, "lz_tens", 8'hC0);
`endif
        show(2'b01, "lz_units", 8'hF8);
    endtask

    task automatic test_toggle();
        load(7'd42);
        wait_idle("tog_idle");
        Column_Scan_Sig = 2'b01;
        tick();
        for (int i = 0; i < 6; i++) begin
            Column_Scan_Sig = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            chk_row($sformatf("tog_lag%0d", i),
                    (i % 2 == 0) ? 8'hA4 : 8'h99);
            tick();
            chk_row($sformatf("tog_now%0d", i),
                    (i % 2 == 0) ? 8'h99 : 8'hA4);
        end
    endtask

    initial begin
        test_reset();
        test_convert_42();
        test_overflow();
        test_boundary_99();
        test_ignore_busy();
        test_valid_held();
        test_reset_mid_conv();
        test_leading_zero();
        test_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
